led_uart_counter_gen: RTL and testbench

LED_UART_COUNTER_GEN -- requirements
Module: led_uart_counter_gen

---
 rtl/led_uart_counter_gen.sv | 190 +++++++++++++++++++
 tb/tb_led_uart_counter_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_uart_counter_gen.sv
// Free-running up/down LED counter whose every step is also sent as an 8N1-style
// UART frame (optional parity, 1 or 2 stop bits) through a one-deep holding register.
module led_uart_counter_gen #(
  parameter int CNT_WIDTH  = 4,
  parameter int TICK_DIV   = 12_000_000,
  parameter int BAUD_DIV   = 104,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 up_down,
  output logic [CNT_WIDTH-1:0] led,
  output logic                 tx,
  output logic                 busy,
  output logic                 overrun
);

  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
  localparam int BW       = (STOP_LEN > 2) ? $clog2(STOP_LEN) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_LEN - 1);
  localparam logic          PAR_ODD    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Prescaler and counter
  // ---------------------------------------------------------------------------
  logic [PW-1:0]        presc_q;
  logic                 tick;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_next;

  assign tick     = en && (presc_q == PRESC_LAST);
  assign cnt_next = up_down ? cnt_q + CNT_WIDTH'(1) : cnt_q - CNT_WIDTH'(1);
  assign led      = cnt_q;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (en) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register: one pending value, newest tick wins
  // ---------------------------------------------------------------------------
  state_t     state_q;
  state_t     state_d;
  logic [7:0] hold_q;
  logic       pend_q;
  logic       overrun_q;
  logic       consume;

  assign consume = (state_q == IDLE) && pend_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      hold_q    <= '0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (tick) begin
        cnt_q  <= cnt_next;
        hold_q <= 8'(cnt_next);
        pend_q <= 1'b1;
        // Overwriting a value the transmitter is taking this same edge is not a loss.
        overrun_q <= pend_q && !consume;
      end else if (consume) begin
        pend_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM; tx and busy are computed one cycle ahead and registered
  // ---------------------------------------------------------------------------
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (pend_q) begin
          state_d = START;
          shift_d = hold_q;
          par_d   = (^hold_q) ^ PAR_ODD;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // shift_q[0] is the bit now on the line, so shift_q[1] goes next.
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (baud_q == BAUD_LAST) begin
          state_d = STOP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (baud_q == STOP_LAST) begin
          state_d = IDLE;
          baud_d  = '0;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_led_uart_counter_gen.sv
// Directed bench for led_uart_counter_gen: four parameterisations, a byte scoreboard
// fed at each tick and drained by a cycle-exact frame decoder.
module tb_led_uart_counter_gen;

  localparam int TICK = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, reset_o, up_down;
  logic       en_a, en_b, en_c, en_d;
  logic [3:0] led_a, led_b, led_d;
  logic [7:0] led_c;
  logic       tx_a, tx_b, tx_c, tx_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       ov_a, ov_b, ov_c, ov_d;

  led_uart_counter_gen #(.CNT_WIDTH(4), .TICK_DIV(TICK), .BAUD_DIV(2), .PARITY_EN(1),
                         .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset_a), .en(en_a), .up_down(up_down),
    .led(led_a), .tx(tx_a), .busy(busy_a), .overrun(ov_a));

  led_uart_counter_gen #(.CNT_WIDTH(4), .TICK_DIV(TICK), .BAUD_DIV(8), .PARITY_EN(1),
                         .PARITY_ODD(0), .STOP_BITS(2)) u_b (
    .clk(clk), .reset(reset_o), .en(en_b), .up_down(up_down),
    .led(led_b), .tx(tx_b), .busy(busy_b), .overrun(ov_b));

  led_uart_counter_gen #(.CNT_WIDTH(8), .TICK_DIV(TICK), .BAUD_DIV(4), .PARITY_EN(1),
                         .PARITY_ODD(1), .STOP_BITS(1)) u_c (
    .clk(clk), .reset(reset_o), .en(en_c), .up_down(up_down),
    .led(led_c), .tx(tx_c), .busy(busy_c), .overrun(ov_c));

  led_uart_counter_gen #(.CNT_WIDTH(4), .TICK_DIV(TICK), .BAUD_DIV(4), .PARITY_EN(0),
                         .PARITY_ODD(0), .STOP_BITS(1)) u_d (
    .clk(clk), .reset(reset_o), .en(en_d), .up_down(up_down),
    .led(led_d), .tx(tx_d), .busy(busy_d), .overrun(ov_d));

  logic [1:0] sel;
  logic       tx_mon, busy_mon, ov_mon;
  logic [7:0] led_mon;

  always_comb begin
    tx_mon   = tx_a;
    busy_mon = busy_a;
    ov_mon   = ov_a;
    led_mon  = {4'b0, led_a};
    case (sel)
      2'd1: begin tx_mon = tx_b; busy_mon = busy_b; ov_mon = ov_b; led_mon = {4'b0, led_b}; end
      2'd2: begin tx_mon = tx_c; busy_mon = busy_c; ov_mon = ov_c; led_mon = led_c; end
      2'd3: begin tx_mon = tx_d; busy_mon = busy_d; ov_mon = ov_d; led_mon = {4'b0, led_d}; end
      default: ;
    endcase
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb_q[$];
  int         model[4];
  int         ov_cyc_a = 0;
  int         ov_cyc_b = 0;
  int         ov_rise_b = 0;
  logic       ov_b_prev = 1'b0;

  always @(negedge clk) begin
    if (ov_a === 1'b1) ov_cyc_a++;
    if (ov_b === 1'b1) ov_cyc_b++;
    if (ov_b === 1'b1 && ov_b_prev !== 1'b1) ov_rise_b++;
    ov_b_prev = ov_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_en(input int which, input logic v);
    case (which)
      0: en_a = v;
      1: en_b = v;
      2: en_c = v;
      default: en_d = v;
    endcase
  endtask

  // One counter step: en high for exactly TICK cycles, then the expected byte is queued.
  task automatic step(input int which, input logic up, input int mask);
    up_down = up;
    set_en(which, 1'b1);
    cyc(TICK);
    set_en(which, 1'b0);
    model[which] = up ? (model[which] + 1) & mask : (model[which] - 1) & mask;
    sb_q.push_back(8'(model[which]));
    check($sformatf("dut%0d led after tick", which), 32'(led_mon), 32'(model[which]));
  endtask

  // Waits (bounded) for a start bit, then checks every cycle of the frame against the
  // popped byte and requires busy to drop exactly after the last stop cycle.
  task automatic get_frame(input int b, input int pe, input logic po, input int sb,
                           input string tag);
    int         waited;
    int         n;
    logic [7:0] d;
    logic [11:0] bits;
    logic       obs_tx;
    logic       bad_busy;
    waited = 0;
    while (tx_mon !== 1'b0 && waited < 300) begin
      cyc(1);
      waited++;
    end
    check({tag, " start bit seen"}, 32'(tx_mon), 32'(0));
    if (tx_mon !== 1'b0) return;
    check({tag, " scoreboard nonempty"}, 32'(sb_q.size() > 0), 32'(1));
    d = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
    n = 9 + pe + sb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pe != 0) bits[9] = (^d) ^ po;
    for (int i = 0; i < n; i++) begin
      obs_tx = bits[i];
      bad_busy = 1'b0;
      for (int j = 0; j < b; j++) begin
        if (tx_mon !== bits[i]) obs_tx = tx_mon;
        if (busy_mon !== 1'b1) bad_busy = 1'b1;
        cyc(1);
      end
      check($sformatf("%s data=0x%02h bit%0d {busy_bad,tx}", tag, d, i),
            {30'b0, bad_busy, obs_tx}, {30'b0, 1'b0, bits[i]});
    end
    check({tag, " busy low after frame"}, 32'(busy_mon), 32'(0));
    check({tag, " tx idle after frame"}, 32'(tx_mon), 32'(1));
  endtask

  initial begin
    reset_a = 1'b1; reset_o = 1'b1; up_down = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    sel = 2'd0;
    model = '{default: 0};
    cyc(3);
    check("reset led", 32'(led_mon), 32'(0));
    check("reset tx", 32'(tx_mon), 32'(1));
    check("reset busy", 32'(busy_mon), 32'(0));
    check("reset overrun", 32'(ov_mon), 32'(0));
    reset_a = 1'b0;
    reset_o = 1'b0;

    // First tick only after TICK_DIV enabled cycles, frame starts one cycle later.
    en_a = 1'b1;
    cyc(TICK - 1);
    check("no tick before TICK_DIV", 32'(led_mon), 32'(0));
    cyc(1);
    en_a = 1'b0;
    model[0] = 1;
    sb_q.push_back(8'h01);
    check("first tick led", 32'(led_mon), 32'(1));
    check("tx idle on tick edge", 32'(tx_mon), 32'(1));
    check("busy low on tick edge", 32'(busy_mon), 32'(0));
    cyc(1);
    check("tx falls 1 clk after tick", 32'(tx_mon), 32'(0));
    check("busy rises with start bit", 32'(busy_mon), 32'(1));
    get_frame(2, 1, 1'b0, 1, "a first");

    // Count up through the wrap 15 -> 0.
    for (int k = 0; k < 15; k++) begin
      step(0, 1'b1, 15);
      get_frame(2, 1, 1'b0, 1, "a up");
    end
    check("up wrap led", 32'(led_mon), 32'(0));

    // Prescaler freezes with en low while a frame is in flight; inputs wiggle meanwhile.
    step(0, 1'b1, 15);
    fork
      begin
        cyc(2);
        en_a = 1'b1;
        cyc(2);
        en_a = 1'b0;
        up_down = 1'b0;
        cyc(20);
        up_down = 1'b1;
      end
    join_none
    get_frame(2, 1, 1'b0, 1, "a freeze");
    cyc(3);
    check("led frozen with en low", 32'(led_mon), 32'(model[0]));
    en_a = 1'b1;
    cyc(1);
    check("prescaler kept count", 32'(led_mon), 32'(model[0]));
    cyc(1);
    en_a = 1'b0;
    model[0] = (model[0] + 1) & 15;
    sb_q.push_back(8'(model[0]));
    check("tick after resumed prescaler", 32'(led_mon), 32'(model[0]));
    get_frame(2, 1, 1'b0, 1, "a resume");

    // Reset in DATA bit 3 aborts the frame at once.
    en_a = 1'b1;
    cyc(TICK);
    en_a = 1'b0;
    cyc(1);
    check("aborted frame started", 32'(tx_mon), 32'(0));
    cyc(8);
    reset_a = 1'b1;
    #1;
    check("mid-frame reset tx", 32'(tx_mon), 32'(1));
    check("mid-frame reset busy", 32'(busy_mon), 32'(0));
    check("mid-frame reset led", 32'(led_mon), 32'(0));
    model[0] = 0;
    cyc(2);
    reset_a = 1'b0;
    cyc(10);
    check("no frame before tick busy", 32'(busy_mon), 32'(0));
    check("no frame before tick tx", 32'(tx_mon), 32'(1));
    step(0, 1'b0, 15);
    get_frame(2, 1, 1'b0, 1, "a down");
    check("dut a never overran", 32'(ov_cyc_a), 32'(0));

    // Ticks overwrite pending value during a long frame.
    sel = 2'd1;
    up_down = 1'b1;
    sb_q.push_back(8'h01);
    sb_q.push_back(8'h05);
    en_b = 1'b1;
    fork
      begin
        cyc(5 * TICK);
        en_b = 1'b0;
      end
    join_none
    get_frame(8, 1, 1'b0, 2, "b first");
    cyc(1);
    check("b next frame after one idle cycle tx", 32'(tx_mon), 32'(0));
    check("b next frame after one idle cycle busy", 32'(busy_mon), 32'(1));
    get_frame(8, 1, 1'b0, 2, "b latest");
    check("b led", 32'(led_mon), 32'(5));
    check("b overrun high cycles", 32'(ov_cyc_b), 32'(3));
    check("b overrun pulses", 32'(ov_rise_b), 32'(3));

    // Odd parity, 8-bit counter.
    sel = 2'd2;
    for (int k = 0; k < 3; k++) begin
      step(2, 1'b1, 255);
      get_frame(4, 1, 1'b1, 1, "c odd");
    end

    // No parity: 10-bit frames.
    sel = 2'd3;
    step(3, 1'b0, 15);
    get_frame(4, 0, 1'b0, 1, "d down wrap");
    step(3, 1'b1, 15);
    get_frame(4, 0, 1'b0, 1, "d up wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
